// File: rtl/rx_line_capture_pkg.sv
// Shared types and constants for the RX line-capture stream path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: FSM state enum, header/trailer tags, stream entry layout, channel-sum helper.
package rx_line_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_TRAIL,
        ST_FLUSH
    } state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam logic [3:0] TRL_TAG = 4'h5;

    localparam int ENTRY_W = 18;
    localparam int NUM_CH  = 8;
    localparam int CH_W    = 12;
    localparam int SUM_W   = 15;

    // One stream word as stored in the output FIFO.
    typedef struct packed {
        logic        hdr;
        logic        last;
        logic [15:0] data;
    } entry_t;

    // Zero-extended sum of all ADC channels; 8 x 4095 fits in 15 bits.
    function automatic logic [SUM_W-1:0] chan_sum(input logic [NUM_CH*CH_W-1:0] ch);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc = acc + SUM_W'(ch[i*CH_W +: CH_W]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rx_stream_fifo.sv
// Synchronous first-word-fall-through FIFO holding the capture stream words.
// Latency: a pushed word is visible at head one cycle after the push.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
// Ports: clk/rst, push + push_data (write side), pop (read side), head, full, empty.
module rx_stream_fifo
    import rx_line_capture_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign do_pop  = pop && !empty;
    // When full, the slot being popped this cycle is reused by the push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rx_line_capture.sv
// Captures one ultrasound receive line: header, channel-sum samples, trailer into a stream FIFO.
// Latency: sample accepted at cycle N is at the output at N+2 (FIFO empty); trailer pushed 2 cycles after end_gate.
// Backpressure: out_valid/out_ready handshake; words pushed into a full FIFO are dropped and flagged.
// Ports: clk/reset; gates pr/rx/sample/end; line_num, focus_num, data_a..data_h in;
//        out_data/out_hdr/out_last/out_valid/out_ready stream; sample_cnt, busy, err_overflow, err_protocol status.
module rx_line_capture
    import rx_line_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pr_gate,
    input  logic             rx_gate,
    input  logic             sample_gate,
    input  logic             end_gate,
    input  logic [7:0]       line_num,
    input  logic [1:0]       focus_num,
    input  logic [11:0]      data_a,
    input  logic [11:0]      data_b,
    input  logic [11:0]      data_c,
    input  logic [11:0]      data_d,
    input  logic [11:0]      data_e,
    input  logic [11:0]      data_f,
    input  logic [11:0]      data_g,
    input  logic [11:0]      data_h,
    output logic [15:0]      out_data,
    output logic             out_hdr,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             busy,
    output logic             err_overflow,
    output logic             err_protocol
);

    state_t             state;
    state_t             state_nxt;
    logic               pr_prev;
    logic               pr_low_seen;
    logic               pr_rise;
    logic [7:0]         line_q;
    logic [1:0]         focus_q;
    logic               hdr_pend;
    logic               trl_pend;
    logic               pipe_vld;
    logic [SUM_W-1:0]   pipe_sum;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_max;
    logic               sample_req;
    logic               accept;
    logic               prot_evt;
    logic               err_ovf_q;
    logic               err_prot_q;
    logic [11:0]        cnt_field;
    logic               push;
    entry_t             push_entry;
    entry_t             head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    // A rise only counts once pr_gate has been seen low since reset, so a gate
    // held high across reset release does not start a spurious line.
    assign pr_rise    = pr_gate && !pr_prev && pr_low_seen;
    assign cnt_max    = &cnt;
    assign sample_req = (state == ST_CAPTURE) && sample_gate && rx_gate;
    assign accept     = sample_req && !cnt_max;
    assign cnt_field  = 12'(cnt);

    assign prot_evt = (pr_rise && (state != ST_IDLE))
                   || (end_gate && (state == ST_IDLE))
                   || ((state == ST_CAPTURE) && sample_gate && !rx_gate)
                   || (sample_req && cnt_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Push sources are mutually exclusive by construction: the header goes out in
    // the first ARMED cycle, samples one cycle after acceptance (CAPTURE/TRAIL), and
    // the trailer in the first FLUSH cycle, after the last sample has left the pipe.
    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_entry = '0;

        case (state)
            ST_IDLE:    if (pr_rise) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (end_gate)     state_nxt = ST_TRAIL;
                else if (rx_gate) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: if (end_gate) state_nxt = ST_TRAIL;
            ST_TRAIL:   state_nxt = ST_FLUSH;
            ST_FLUSH:   if (!trl_pend && fifo_empty) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase

        if (hdr_pend) begin
            push            = 1'b1;
            push_entry.hdr  = 1'b1;
            push_entry.data = {HDR_TAG, focus_q, 2'b00, line_q};
        end else if (pipe_vld) begin
            push            = 1'b1;
            push_entry.data = {1'b0, pipe_sum};
        end else if (trl_pend) begin
            push            = 1'b1;
            push_entry.last = 1'b1;
            push_entry.data = {TRL_TAG, cnt_field};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pr_prev     <= 1'b0;
            pr_low_seen <= 1'b0;
            line_q      <= '0;
            focus_q     <= '0;
            hdr_pend    <= 1'b0;
            trl_pend    <= 1'b0;
            pipe_vld    <= 1'b0;
            pipe_sum    <= '0;
            cnt         <= '0;
            err_ovf_q   <= 1'b0;
            err_prot_q  <= 1'b0;
        end else begin
            pr_prev  <= pr_gate;
            if (!pr_gate) pr_low_seen <= 1'b1;

            hdr_pend <= 1'b0;
            if ((state == ST_IDLE) && pr_rise) begin
                line_q   <= line_num;
                focus_q  <= focus_num;
                cnt      <= '0;
                hdr_pend <= 1'b1;
            end else if (accept) begin
                cnt <= cnt + CNT_W'(1);
            end

            pipe_vld <= accept;
            if (accept) pipe_sum <= chan_sum({data_h, data_g, data_f, data_e,
                                              data_d, data_c, data_b, data_a});

            // One-cycle pulse on the first FLUSH cycle.
            trl_pend <= (state == ST_TRAIL);

            if (push && fifo_full && !pop) err_ovf_q  <= 1'b1;
            if (prot_evt)                  err_prot_q <= 1'b1;
        end
    end

    rx_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid    = !fifo_empty;
    assign pop          = out_valid && out_ready;
    // Memory contents are not reset, so the word fields are forced to zero when empty.
    assign out_data     = fifo_empty ? 16'h0000 : head.data;
    assign out_hdr      = !fifo_empty && head.hdr;
    assign out_last     = !fifo_empty && head.last;
    assign sample_cnt   = cnt;
    assign busy         = (state != ST_IDLE);
    assign err_overflow = err_ovf_q;
    assign err_protocol = err_prot_q;

endmodule

// File: tb/tb_rx_line_capture.sv
module tb_rx_line_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        pr_gate, rx_gate, sample_gate, end_gate;
    logic [7:0]  line_num;
    logic [1:0]  focus_num;
    logic [11:0] ch [8];
    logic [11:0] data_a, data_b, data_c, data_d, data_e, data_f, data_g, data_h;
    logic [15:0] out_data;
    logic        out_hdr, out_last, out_valid, out_ready;
    logic [9:0]  sample_cnt;
    logic        busy, err_overflow, err_protocol;

    int          total = 0;
    int          bad   = 0;
    logic [17:0] exp_q [$];
    logic [17:0] mon_exp;
    int          model_cnt = 0;
    bit          rnd_ready = 1'b0;

    assign data_a = ch[0];
    assign data_b = ch[1];
    assign data_c = ch[2];
    assign data_d = ch[3];
    assign data_e = ch[4];
    assign data_f = ch[5];
    assign data_g = ch[6];
    assign data_h = ch[7];

    always #5 clk = ~clk;

    rx_line_capture #(.FIFO_DEPTH(16), .CNT_W(10)) dut (
        .clk (clk), .reset (reset),
        .pr_gate (pr_gate), .rx_gate (rx_gate), .sample_gate (sample_gate), .end_gate (end_gate),
        .line_num (line_num), .focus_num (focus_num),
        .data_a (data_a), .data_b (data_b), .data_c (data_c), .data_d (data_d),
        .data_e (data_e), .data_f (data_f), .data_g (data_g), .data_h (data_h),
        .out_data (out_data), .out_hdr (out_hdr), .out_last (out_last),
        .out_valid (out_valid), .out_ready (out_ready),
        .sample_cnt (sample_cnt), .busy (busy),
        .err_overflow (err_overflow), .err_protocol (err_protocol)
    );

    // Scoreboard: every accepted output word must be the next expected word.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            else                  mon_exp = 'x;
            total++;
            assert ({out_hdr, out_last, out_data} === mon_exp) else begin
                bad++;
                $error("FAIL stream_word: got=%h expected=%h", {out_hdr, out_last, out_data}, mon_exp);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Expected words straight from the line format: {hdr, last, 16-bit word}.
    function automatic logic [17:0] hdr_word(input logic [7:0] ln, input logic [1:0] fc);
        return {1'b1, 1'b0, 4'hA, fc, 2'b00, ln};
    endfunction

    function automatic logic [17:0] trl_word(input int n);
        logic [11:0] c;
        c = 12'(n);
        return {1'b0, 1'b1, 4'h5, c};
    endfunction

    task automatic start_line(input logic [7:0] ln, input logic [1:0] fc);
        line_num  = ln;
        focus_num = fc;
        pr_gate   = 1'b1;
        exp_q.push_back(hdr_word(ln, fc));
        model_cnt = 0;
        tick();
        pr_gate   = 1'b0;
        line_num  = 8'($urandom);
        focus_num = 2'($urandom);
        rx_gate   = 1'b1;
        tick();
    endtask

    task automatic sample(input bit rnd, input logic [11:0] v, input bit with_end);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            ch[i] = rnd ? 12'($urandom) : v;
            s += int'(ch[i]);
        end
        if (model_cnt < 1023) begin
            exp_q.push_back({2'b00, 16'(s)});
            model_cnt++;
        end
        sample_gate = 1'b1;
        rx_gate     = 1'b1;
        end_gate    = with_end;
        if (with_end) exp_q.push_back(trl_word(model_cnt));
        tick();
        sample_gate = 1'b0;
        end_gate    = 1'b0;
        if (with_end) rx_gate = 1'b0;
    endtask

    task automatic end_line();
        end_gate = 1'b1;
        rx_gate  = 1'b0;
        exp_q.push_back(trl_word(model_cnt));
        tick();
        end_gate = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        total++;
        assert (busy === 1'b0) else begin
            bad++;
            $error("FAIL %s_timeout: busy=%0b expected=0", tag, busy);
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        pr_gate = 1'b1;
        rx_gate = 1'b0; sample_gate = 1'b0; end_gate = 1'b0;
        line_num = '0; focus_num = '0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) ch[i] = '0;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_hdr", out_hdr, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_err_protocol", err_protocol, 0);

        // pr_gate held high across release is not an edge
        reset = 1'b0;
        repeat (3) tick();
        chk("no_edge_after_reset", busy, 0);
        pr_gate = 1'b0;
        tick();

        // Nominal line, with accept-to-output latency check on the first sample
        start_line(8'h2C, 2'd2);
        sample(1'b0, 12'h001, 1'b0);
        chk("lat_n1_valid", out_valid, 0);
        tick();
        chk("lat_n2_valid", out_valid, 1);
        sample(1'b0, 12'h100, 1'b0);
        sample(1'b0, 12'hFFF, 1'b0);
        chk("nom_sample_cnt", sample_cnt, 3);
        end_line();
        chk("nom_busy_flush", busy, 1);
        wait_idle("nom");
        chk("nom_err_overflow", err_overflow, 0);
        chk("nom_err_protocol", err_protocol, 0);

        // end_gate together with a sample: sample counted, trailer two cycles later
        start_line(8'($urandom), 2'($urandom));
        sample(1'b1, 12'h0, 1'b0);
        sample(1'b1, 12'h0, 1'b0);
        sample(1'b1, 12'h0, 1'b1);
        chk("sim_sample_cnt", sample_cnt, 3);
        tick();
        chk("sim_last_early", out_last, 0);
        tick();
        chk("sim_last_ontime", out_last, 1);
        wait_idle("sim");

        // Second pr_gate rise during CAPTURE: flagged, line continues
        start_line(8'h11, 2'd1);
        sample(1'b1, 12'h0, 1'b0);
        pr_gate = 1'b1;
        tick();
        pr_gate = 1'b0;
        chk("prot_pr_flag", err_protocol, 1);
        chk("prot_pr_busy", busy, 1);
        sample(1'b1, 12'h0, 1'b0);
        chk("prot_pr_cnt", sample_cnt, 2);
        end_line();
        wait_idle("prot_pr");
        do_reset();
        chk("prot_clear", err_protocol, 0);

        // end_gate in IDLE
        end_gate = 1'b1;
        tick();
        end_gate = 1'b0;
        tick();
        chk("prot_end_flag", err_protocol, 1);
        chk("prot_end_busy", busy, 0);
        chk("prot_end_valid", out_valid, 0);

        // Backpressure: 18 samples into a stalled 16-entry FIFO
        do_reset();
        out_ready = 1'b0;
        start_line(8'($urandom), 2'($urandom));
        for (int i = 0; i < 18; i++) begin
            sample(1'b1, 12'h0, 1'b0);
            chk("bp_hold_data", out_data, 32'(exp_q[0][15:0]));
        end
        end_line();
        tick();
        tick();
        // Nothing was popped, so everything past the first 16 words was dropped.
        while (exp_q.size() > 16) void'(exp_q.pop_back());
        chk("bp_sample_cnt", sample_cnt, 18);
        chk("bp_err_overflow", err_overflow, 1);
        chk("bp_hold_final", out_data, 32'(exp_q[0][15:0]));
        chk("bp_busy", busy, 1);
        out_ready = 1'b1;
        wait_idle("bp");

        // Reset in the middle of CAPTURE with 5 words buffered
        do_reset();
        out_ready = 1'b0;
        start_line(8'($urandom), 2'($urandom));
        repeat (4) sample(1'b1, 12'h0, 1'b0);
        tick();
        tick();
        chk("mid_valid_before", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_cnt", sample_cnt, 0);
        chk("mid_err_overflow", err_overflow, 0);
        chk("mid_err_protocol", err_protocol, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        rx_gate = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("mid_no_trailer", out_valid, 0);
        chk("mid_idle", busy, 0);

        // Random lines with random consumer stalls
        rnd_ready = 1'b1;
        for (int l = 0; l < 10; l++) begin
            int n;
            bit ended;
            n = $urandom_range(0, 10);
            ended = 1'b0;
            start_line(8'($urandom), 2'($urandom));
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                if (k == n - 1 && $urandom_range(0, 1) == 1) begin
                    sample(1'b1, 12'h0, 1'b1);
                    ended = 1'b1;
                end else begin
                    sample(1'b1, 12'h0, 1'b0);
                end
            end
            if (!ended) end_line();
            wait_idle("rnd");
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        chk("rnd_err_overflow", err_overflow, 0);
        chk("rnd_err_protocol", err_protocol, 0);

        // Counter saturation: 1025 samples, last two dropped
        start_line(8'($urandom), 2'($urandom));
        for (int i = 0; i < 1025; i++) sample(1'b1, 12'h0, 1'b0);
        tick();
        chk("sat_cnt", sample_cnt, 1023);
        chk("sat_err_protocol", err_protocol, 1);
        end_line();
        wait_idle("sat");
        chk("sat_err_overflow", err_overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_line_capture.md
RX_LINE_CAPTURE -- requirements
Module: rx_line_capture

Interface
REQ-001 Parameters (name, default, meaning):
- FIFO_DEPTH, 16, output FIFO entries, power of two.
- CNT_W, 10, sample-counter width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all inputs are synchronous to it.
- reset, in, 1, asynchronous, active-high.
- pr_gate, in, 1, pulse-repetition gate; a rising edge starts a line.
- rx_gate, in, 1, receive window.
- sample_gate, in, 1, sample qualifier.
- end_gate, in, 1, end-of-line strobe.
- line_num, in, 8, line index.
- focus_num, in, 2, focus index.
- data_a..data_h, in, 12 each, unsigned ADC channel samples.
- out_data, out, 16, stream word.
- out_hdr, out, 1, current word is a header.
- out_last, out, 1, current word is a trailer.
- out_valid, out, 1, word available.
- out_ready, in, 1, consumer accepts the word.
- sample_cnt, out, CNT_W, samples accepted on the current line.
- busy, out, 1, high when state is not IDLE.
- err_overflow, out, 1, sticky: a word was dropped because the FIFO was full.
- err_protocol, out, 1, sticky: a gate arrived out of sequence.

Function
REQ-003 FSM states: IDLE, ARMED, CAPTURE, TRAIL, FLUSH.
REQ-004 IDLE -> ARMED on a pr_gate rising edge (registered previous value, 0 -> 1):
- latch line_num and focus_num;
- clear sample_cnt;
- push header {4'hA, focus_num, 2'b00, line_num} with hdr=1.
REQ-005 ARMED -> CAPTURE when rx_gate=1.
REQ-006 ARMED or CAPTURE -> TRAIL on end_gate=1.
REQ-007 In CAPTURE, a cycle with sample_gate=1 and rx_gate=1 accepts one sample:
- sum = zero-extended sum of data_a..data_h (15 bits, range 0..32760), registered in one pipeline stage;
- the sum is pushed one cycle later as {1'b0, sum}.
REQ-008 Accept-to-output latency: a sample accepted at cycle N with the FIFO empty gives out_valid=1 at N+2.
REQ-009 sample_cnt increments by 1 per accepted sample and saturates at 2^CNT_W-1. After saturation, further samples are dropped and err_protocol is set.
REQ-010 Simultaneous end_gate and a valid sample in CAPTURE: the sample is accepted and counted before the trailer.
REQ-011 Trailer timing: with end_gate at cycle N, state is TRAIL at N+1 and the trailer is pushed at N+2. This lets the pipeline drain, so sample and trailer pushes never collide.
REQ-012 Trailer word is {4'h5, 2'b00, sample_cnt} (10 bits at CNT_W=10) with last=1. TRAIL then goes to FLUSH.
REQ-013 FLUSH -> IDLE when the FIFO is empty; busy stays 1 until then.
REQ-014 FIFO pops when out_valid=1 and out_ready=1. out_data, out_hdr and out_last stay stable while out_valid=1 and out_ready=0.
REQ-015 A push while the FIFO is full drops the word (header, sample or trailer) and sets err_overflow. A simultaneous pop and push when full succeeds.
REQ-016 Protocol errors set err_protocol and are otherwise ignored:
- a pr_gate rising edge when not IDLE;
- end_gate=1 in IDLE;
- sample_gate=1 while rx_gate=0 in CAPTURE.
REQ-017 Sticky errors clear only on reset.

Reset
REQ-018 Reset, asynchronous and active-high, forces:
- state IDLE;
- FIFO empty;
- out_valid=0, out_data=0, out_hdr=0, out_last=0;
- sample_cnt=0, busy=0, err_overflow=0, err_protocol=0;
- pipeline register and edge register cleared.
REQ-019 Reset mid-line discards all buffered words. No trailer is emitted.
REQ-020 After reset release, the first pr_gate rising edge is detected only if pr_gate was sampled low for at least one cycle after release.

Structure
REQ-021 A shared package holds:
- the state enumeration;
- header tag 4'hA and trailer tag 4'h5;
- the FIFO entry width (18).
REQ-022 One sub-module, rx_stream_fifo: synchronous FIFO, FIFO_DEPTH x 18, with full/empty flags and first-word-fall-through output. The FSM, edge detection and adder pipeline live in rx_line_capture.

Verification
REQ-023 Nominal line:
- stimulus: line_num=8'h2C, focus_num=2, out_ready=1, three samples with all channels = 12'h001, 12'h100, 12'hFFF;
- response: words 16'hA82C (hdr), 16'h0008, 16'h0800, 16'h7FF8, 16'h5003 (last).
REQ-024 Backpressure:
- stimulus: out_ready=0 for 20 cycles, 18 samples;
- response: 16 words held, err_overflow=1, trailer dropped, sample_cnt=18, out_data stable throughout.
REQ-025 Simultaneous events: end_gate on the same cycle as a sample -> trailer count includes that sample; trailer appears 2 cycles after end_gate.
REQ-026 Protocol errors: a second pr_gate rise in CAPTURE, or end_gate in IDLE -> err_protocol=1, state unchanged.
REQ-027 Reset mid-CAPTURE with 5 words buffered -> out_valid=0 next cycle, state IDLE, all flags 0.
